// File: rtl/tmp_dec_pkg.sv
// Shared types and default sizing for the temperature-sensor pulse decoder.
// TMP_AVG_EN (optional define) enables frame averaging in tmp_pulse_decoder.
package tmp_dec_pkg;

  localparam int TMP_CNT_W    = 6;
  localparam int TMP_AVG_LOG2 = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } tmp_state_e;

  // Result word at the default counter width, as seen by the readout register file.
  typedef struct packed {
    logic signed [TMP_CNT_W:0] diff;
    logic        [TMP_CNT_W:0] total;
  } tmp_res_t;

endpackage

// File: rtl/tmp_edge_cnt.sv
// Edge detector plus saturating per-frame packet counter with a sticky saturation flag.
// ACT_LOW selects falling-edge (active-low line) instead of rising-edge detection.
module tmp_edge_cnt
  import tmp_dec_pkg::*;
#(
  parameter int CNT_W   = TMP_CNT_W,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat
);

  logic             line_q;
  logic             evt;
  logic             at_max;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) line_q <= ACT_LOW;
    else       line_q <= line;
  end

  assign evt    = en & (ACT_LOW ? (line_q & ~line) : (line & ~line_q));
  assign at_max = &cnt_q;

  // Count including this cycle's event, so a closing frame sees its last packet.
  assign cnt_nxt = (evt && !at_max) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)                sat <= 1'b0;
    else if (evt && at_max)   sat <= 1'b1;
  end

endmodule

// File: rtl/tmp_pulse_decoder.sv
// Charge-balance receive side: counts sink/source packets per frame and emits src-snk and src+snk.
// Optional frame averaging is enabled by defining TMP_AVG_EN.
//
// state | meaning
// IDLE  | precharge / aborted; counters held at zero, events and frm_end ignored
// COUNT | frame open, sink and source packets counted
// LATCH | frame closed; captured counts go to the averager / output register
module tmp_pulse_decoder
  import tmp_dec_pkg::*;
#(
  parameter int CNT_W    = TMP_CNT_W,
  parameter int AVG_LOG2 = TMP_AVG_LOG2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               snk,
  input  logic               src_n,
  input  logic               preChrg,
  input  logic               frm_end,
  output logic signed [CNT_W:0] res_diff,
  output logic        [CNT_W:0] res_total,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               overrun,
  output logic               sat
);

  typedef struct packed {
    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] total;
  } res_t;

  tmp_state_e       state_q, state_d;
  logic             en, close, clr, latch, load;
  logic [CNT_W-1:0] snk_cnt, src_cnt;
  logic             sat_snk, sat_src;
  res_t             frm_res, frm_q, new_res, out_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!preChrg) state_d = COUNT;
      COUNT:   if (frm_end)  state_d = LATCH;
      LATCH:   state_d = COUNT;
      default: state_d = IDLE;
    endcase
    if (preChrg) state_d = IDLE;
  end

  assign en    = (state_q != IDLE) && !preChrg;
  assign close = (state_q == COUNT) && frm_end && !preChrg;
  assign clr   = !en || close;
  assign latch = (state_q == LATCH) && !preChrg;

  tmp_edge_cnt #(.CNT_W(CNT_W), .ACT_LOW(1'b0)) u_snk_cnt (
    .clk     (clk),
    .reset   (reset),
    .line    (snk),
    .en      (en),
    .clr     (clr),
    .cnt_nxt (snk_cnt),
    .sat     (sat_snk)
  );

  tmp_edge_cnt #(.CNT_W(CNT_W), .ACT_LOW(1'b1)) u_src_cnt (
    .clk     (clk),
    .reset   (reset),
    .line    (src_n),
    .en      (en),
    .clr     (clr),
    .cnt_nxt (src_cnt),
    .sat     (sat_src)
  );

  assign sat = sat_snk | sat_src;

  always_comb begin
    frm_res.diff  = $signed({1'b0, src_cnt}) - $signed({1'b0, snk_cnt});
    frm_res.total = {1'b0, src_cnt} + {1'b0, snk_cnt};
  end

  // Counters restart in the frm_end cycle, so the closing counts are parked here.
  always_ff @(posedge clk) begin
    if (reset)      frm_q <= '0;
    else if (close) frm_q <= frm_res;
  end

`ifdef TMP_AVG_EN
  localparam int ACC_W = CNT_W + 1 + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_diff_q, acc_diff_sum;
  logic        [ACC_W-1:0] acc_tot_q, acc_tot_sum;
  logic     [AVG_LOG2-1:0] idx_q;

  assign acc_diff_sum = acc_diff_q + {{AVG_LOG2{frm_q.diff[CNT_W]}}, frm_q.diff};
  assign acc_tot_sum  = acc_tot_q + {{AVG_LOG2{1'b0}}, frm_q.total};

  always_ff @(posedge clk) begin
    if (reset || preChrg) begin
      acc_diff_q <= '0;
      acc_tot_q  <= '0;
      idx_q      <= '0;
    end else if (latch) begin
      if (&idx_q) begin
        acc_diff_q <= '0;
        acc_tot_q  <= '0;
        idx_q      <= '0;
      end else begin
        acc_diff_q <= acc_diff_sum;
        acc_tot_q  <= acc_tot_sum;
        idx_q      <= idx_q + AVG_LOG2'(1);
      end
    end
  end

  // Dropping the low AVG_LOG2 bits is the floor division (arithmetic for diff).
  assign load = latch && (&idx_q);
  always_comb begin
    new_res.diff  = acc_diff_sum[ACC_W-1:AVG_LOG2];
    new_res.total = acc_tot_sum[ACC_W-1:AVG_LOG2];
  end
`else
  assign load    = latch;
  assign new_res = frm_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (load) begin
        if (!res_valid || res_ready) begin
          out_q     <= new_res;
          res_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end
    end
  end

  assign res_diff  = out_q.diff;
  assign res_total = out_q.total;

endmodule
